// File: rtl/tsr_pkg.sv
// rtl/tsr_pkg.sv - shared FSM encodings and temperature saturation for the sensor reader
package tsr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int T_MAX = 31;

    // Clamp a zero-extended degree value into the controller's 5-bit range
    function automatic logic [4:0] sat5(input logic [31:0] v);
        if (v > 32'(T_MAX)) begin
            return 5'(T_MAX);
        end
        return v[4:0];
    endfunction

endpackage

// File: rtl/tsr_sclk_gen.sv
// rtl/tsr_sclk_gen.sv - sclk divider with rise/fall strobes, idle low when disabled
module tsr_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] div_cnt;
    logic          half_end;

    // A strobe marks the cycle whose closing edge toggles sclk, so the
    // consumer acts on the very edge where sclk changes
    assign half_end = en && (div_cnt == CW'(CLK_DIV - 1));
    assign rise     = half_end && !sclk;
    assign fall     = half_end && sclk;

    // Half-period counter; restarts low whenever the divider is disabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/temp_sensor_reader.sv
// rtl/temp_sensor_reader.sv - serial temperature ADC master feeding the fan/alarm controller
module temp_sensor_reader
    import tsr_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int ADC_BITS = 8,
    parameter int SHIFT    = 1,
    parameter int PERIOD   = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic       muestrear,
    input  logic       sdata,
    output logic       cs_n,
    output logic       sclk,
    output logic [4:0] temperatura,
    output logic       en_m1,
    output logic       lect,
    output logic       sensor_err
);

    localparam int PW = $clog2(PERIOD);
    localparam int BW = $clog2(ADC_BITS + 2);
    localparam int WW = $clog2(CLK_DIV + 1);

    logic [1:0]          state;
    logic [PW-1:0]       period_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [WW-1:0]       wait_cnt;
    logic [ADC_BITS:0]   frame;
    logic [ADC_BITS-1:0] scaled;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                start;

    // Manual request and period expiry collapse into a single start
    assign start  = (state == ST_IDLE) &&
                    (muestrear || (habilitar && (period_cnt == PW'(PERIOD - 1))));
    // Scaling stays at ADC width so large codes saturate instead of wrapping
    assign scaled = frame[ADC_BITS-1:0] >> SHIFT;

    tsr_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clock(clock),
        .reset(reset),
        .en   (state == ST_SHIFT),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Frame sequencing: chip select, setup wait, bit count and period timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cs_n       <= 1'b1;
            period_cnt <= '0;
            wait_cnt   <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETUP;
                        cs_n       <= 1'b0;
                        period_cnt <= '0;
                        wait_cnt   <= '0;
                        bit_cnt    <= '0;
                    end else if (habilitar) begin
                        period_cnt <= period_cnt + 1'b1;
                    end else begin
                        period_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (wait_cnt == WW'(CLK_DIV - 1)) begin
                        state <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (sclk_fall && (bit_cnt == BW'(ADC_BITS + 1))) begin
                        state <= ST_DONE;
                        cs_n  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                end
            endcase
        end
    end

    // Capture sdata on each sclk rising edge; start bit ends up in the MSB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame <= '0;
        end else if ((state == ST_SHIFT) && sclk_rise) begin
            frame <= {frame[ADC_BITS-1:0], sdata};
        end
    end

    // Publish the result of a finished frame to the controller
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            temperatura <= '0;
            en_m1       <= 1'b0;
            lect        <= 1'b0;
            sensor_err  <= 1'b0;
        end else begin
            lect <= 1'b0;
            if (state == ST_DONE) begin
                if (!frame[ADC_BITS]) begin
                    temperatura <= sat5(32'(scaled));
                    lect        <= 1'b1;
                    en_m1       <= 1'b1;
                    sensor_err  <= 1'b0;
                end else begin
                    sensor_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb/tb_temp_sensor_reader.sv - directed self-checking bench with a serial sensor model
module tb_temp_sensor_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilitar = 1'b0;
    logic       muestrear = 1'b0;
    logic       sdata;
    logic       cs_n;
    logic       sclk;
    logic [4:0] temperatura;
    logic       en_m1;
    logic       lect;
    logic       sensor_err;

    int checks = 0;
    int failures = 0;
    int sclk_rises = 0;

    logic [8:0] model_frame = 9'd0;
    int         model_idx = 0;

    temp_sensor_reader #(
        .CLK_DIV (2),
        .ADC_BITS(8),
        .SHIFT   (1),
        .PERIOD  (200)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .habilitar  (habilitar),
        .muestrear  (muestrear),
        .sdata      (sdata),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .temperatura(temperatura),
        .en_m1      (en_m1),
        .lect       (lect),
        .sensor_err (sensor_err)
    );

    always #5 clock = ~clock;

    always @(posedge sclk) sclk_rises++;

    // Sensor model: bit 0 presented while selected, next bit after each sclk fall
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) model_idx = 0;
        else      model_idx++;
    end
    assign sdata = (model_idx <= 8) ? model_frame[8 - model_idx] : 1'b0;

    task automatic run_frame(input logic start_bit, input logic [7:0] code,
                             output int lat, output int pulses, output logic csn_at_start);
        model_frame = {start_bit, code};
        @(posedge clock); #1 muestrear = 1'b1;
        @(posedge clock); #1 muestrear = 1'b0;
        csn_at_start = cs_n;
        lat = -1;
        pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock); #1;
            if (lect) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #50;
        checks += 6;
        if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
        if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        if (temperatura !== 5'd0) begin failures++; $display("FAIL reset_temp got=%0d want=0", temperatura); end
        if (en_m1 !== 1'b0) begin failures++; $display("FAIL reset_en_m1 got=%b want=0", en_m1); end
        if (lect !== 1'b0) begin failures++; $display("FAIL reset_lect got=%b want=0", lect); end
        if (sensor_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", sensor_err); end
        @(negedge clock) reset = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        checks++;
        if (sclk_rises !== 0 || cs_n !== 1'b1) begin
            failures++; $display("FAIL idle_quiet sclk_rises=%0d cs_n=%b want 0 and 1", sclk_rises, cs_n);
        end
    endtask

    task automatic test_single;
        int lat, pulses; logic c0;
        run_frame(1'b0, 8'd40, lat, pulses, c0);
        checks += 6;
        if (c0 !== 1'b0) begin failures++; $display("FAIL start_cs_n got=%b want=0", c0); end
        if (lat !== 39) begin failures++; $display("FAIL latency got=%0d want=39", lat); end
        if (pulses !== 1) begin failures++; $display("FAIL lect_pulses got=%0d want=1", pulses); end
        if (temperatura !== 5'd20) begin failures++; $display("FAIL temp40 got=%0d want=20", temperatura); end
        if (en_m1 !== 1'b1) begin failures++; $display("FAIL en_m1 got=%b want=1", en_m1); end
        if (sensor_err !== 1'b0) begin failures++; $display("FAIL err_clean got=%b want=0", sensor_err); end
    endtask

    task automatic test_scaling;
        int lat, pulses; logic c0;
        run_frame(1'b0, 8'd61, lat, pulses, c0);
        checks += 2;
        if (temperatura !== 5'd30) begin failures++; $display("FAIL temp61 got=%0d want=30", temperatura); end
        if (pulses !== 1) begin failures++; $display("FAIL temp61_pulses got=%0d want=1", pulses); end
        run_frame(1'b0, 8'd200, lat, pulses, c0);
        checks += 2;
        if (temperatura !== 5'd31) begin failures++; $display("FAIL temp200 got=%0d want=31", temperatura); end
        if (lat !== 39) begin failures++; $display("FAIL temp200_latency got=%0d want=39", lat); end
        run_frame(1'b0, 8'd61, lat, pulses, c0);
    endtask

    task automatic test_bad_start;
        int lat, pulses; logic c0;
        run_frame(1'b1, 8'd10, lat, pulses, c0);
        checks += 3;
        if (pulses !== 0) begin failures++; $display("FAIL bad_lect got=%0d want=0", pulses); end
        if (sensor_err !== 1'b1) begin failures++; $display("FAIL bad_err got=%b want=1", sensor_err); end
        if (temperatura !== 5'd30) begin failures++; $display("FAIL bad_temp got=%0d want=30", temperatura); end
        run_frame(1'b0, 8'd50, lat, pulses, c0);
        checks += 2;
        if (sensor_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", sensor_err); end
        if (temperatura !== 5'd25) begin failures++; $display("FAIL temp50 got=%0d want=25", temperatura); end
    endtask

    task automatic test_periodic;
        int f0, f1, nf;
        logic prev;
        f0 = -1; f1 = -1; nf = 0; prev = 1'b1;
        model_frame = {1'b0, 8'd40};
        @(posedge clock); #1 habilitar = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            @(posedge clock); #1;
            if (prev && !cs_n) begin
                nf++;
                if (f0 < 0) f0 = i;
                else if (f1 < 0) f1 = i;
            end
            prev = cs_n;
            muestrear = (f0 > 0 && i == f0 + 10);
            if (f0 > 0 && i >= f0 + 245) break;
        end
        muestrear = 1'b0;
        habilitar = 1'b0;
        repeat (60) @(posedge clock);
        #1;
        checks += 4;
        if (f0 < 0) begin failures++; $display("FAIL auto_start got=none want=frame within 500 cycles"); end
        if (f1 - f0 !== 239) begin failures++; $display("FAIL auto_spacing got=%0d want=239", f1 - f0); end
        if (nf !== 2) begin failures++; $display("FAIL auto_frames got=%0d want=2", nf); end
        if (temperatura !== 5'd20) begin failures++; $display("FAIL auto_temp got=%0d want=20", temperatura); end
    endtask

    task automatic test_reset_mid_frame;
        int lat, pulses; logic c0;
        model_frame = {1'b0, 8'd90};
        @(posedge clock); #1 muestrear = 1'b1;
        @(posedge clock); #1 muestrear = 1'b0;
        repeat (20) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks += 4;
        if (cs_n !== 1'b1) begin failures++; $display("FAIL abort_cs_n got=%b want=1", cs_n); end
        if (sclk !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b want=0", sclk); end
        if (temperatura !== 5'd0) begin failures++; $display("FAIL abort_temp got=%0d want=0", temperatura); end
        if (en_m1 !== 1'b0) begin failures++; $display("FAIL abort_en_m1 got=%b want=0", en_m1); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        run_frame(1'b0, 8'd44, lat, pulses, c0);
        checks += 3;
        if (lat !== 39) begin failures++; $display("FAIL post_reset_latency got=%0d want=39", lat); end
        if (temperatura !== 5'd22) begin failures++; $display("FAIL post_reset_temp got=%0d want=22", temperatura); end
        if (en_m1 !== 1'b1) begin failures++; $display("FAIL post_reset_en_m1 got=%b want=1", en_m1); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_scaling;
        test_bad_start;
        test_periodic;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
